// File: rtl/program_counter_stack.sv
// Program counter with a hardware return-address stack for CALL/RET.
// Drives the shared bus through a tri-state copy and always exposes the PC.
module program_counter_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic             count_increment,
  input  logic             counter_output_enable,
  input  logic [WIDTH-1:0] count_in,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] pc_value,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  localparam int              SPW     = $clog2(DEPTH + 1);
  localparam int              SLOTS   = 2 ** SPW;
  localparam logic [SPW-1:0]  SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0]  SP_ONE  = SPW'(1);
  localparam logic [WIDTH-1:0] PC_ONE = WIDTH'(1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic             push;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc_inc;

  // Sized to the full pointer range so any sp value indexes cleanly; only DEPTH slots are used.
  logic [WIDTH-1:0] stack_q [SLOTS];

  assign pc_inc = pc_q + PC_ONE;
  assign target = count_increment ? (count_in + PC_ONE) : count_in;

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (clr) begin
      pc_d  = '0;
      sp_d  = '0;
      err_d = 1'b0;
    end else if (ret) begin
      if (sp_q != '0) begin
        pc_d = stack_q[sp_q - SP_ONE];
        sp_d = sp_q - SP_ONE;
      end else begin
        err_d = 1'b1;
      end
    end else if (call) begin
      if (sp_q != SP_FULL) begin
        push = 1'b1;
        pc_d = target;
        sp_d = sp_q + SP_ONE;
      end else begin
        err_d = 1'b1;
      end
    end else if (jump) begin
      pc_d = target;
    end else if (count_increment) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      pc_q  <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack contents are don't-care after reset, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[sp_q] <= pc_inc;
    end
  end

  assign pc_value    = pc_q;
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SP_FULL);
  assign stack_err   = err_q;
  assign count_out   = counter_output_enable ? pc_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_program_counter_stack.sv
// Scoreboard bench for program_counter_stack at WIDTH=4, DEPTH=2.
// Stimulus pushes hand-computed expectations; a monitor pops and checks at each falling edge.
module tb_program_counter_stack;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] CLR  = 5'b10000;
  localparam logic [4:0] RET  = 5'b01000;
  localparam logic [4:0] CALL = 5'b00100;
  localparam logic [4:0] JMP  = 5'b00010;
  localparam logic [4:0] INC  = 5'b00001;

  typedef struct {
    string      name;
    logic [3:0] pc;
    logic [3:0] cout;
    logic       empty;
    logic       full;
    logic       err;
  } expT;

  logic       clock = 1'b0;
  logic       rstn;
  logic       clr, jump, call, ret, inc, oe;
  logic [3:0] countIn;
  wire  [3:0] countOut;
  logic [3:0] pcValue;
  logic       stackEmpty, stackFull, stackErr;

  expT sb[$];
  int  compared   = 0;
  int  mismatched = 0;

  program_counter_stack #(.WIDTH(4), .DEPTH(2)) dut (
    .clk                   (clock),
    .rstn                  (rstn),
    .clr                   (clr),
    .jump                  (jump),
    .call                  (call),
    .ret                   (ret),
    .count_increment       (inc),
    .counter_output_enable (oe),
    .count_in              (countIn),
    .count_out             (countOut),
    .pc_value              (pcValue),
    .stack_empty           (stackEmpty),
    .stack_full            (stackFull),
    .stack_err             (stackErr)
  );

  always #5 clock = ~clock;

  task automatic pushExp(input string nm, input logic [3:0] ePc, input logic eEmpty,
                         input logic eFull, input logic eErr);
    expT e;
    e.name  = nm;
    e.pc    = ePc;
    e.cout  = oe ? ePc : 4'bzzzz;
    e.empty = eEmpty;
    e.full  = eFull;
    e.err   = eErr;
    sb.push_back(e);
  endtask

  // One command cycle: drive after the falling edge, expectation queued just after the rising edge.
  task automatic applyStimulus(input logic [4:0] cmd, input logic [3:0] din, input string nm,
                               input logic [3:0] ePc, input logic eEmpty, input logic eFull,
                               input logic eErr);
    @(negedge clock);
    #1;
    {clr, ret, call, jump, inc} = cmd;
    countIn = din;
    @(posedge clock);
    #1;
    {clr, ret, call, jump, inc} = NONE;
    pushExp(nm, ePc, eEmpty, eFull, eErr);
  endtask

  task automatic setOe(input logic val, input string nm, input logic [3:0] ePc,
                       input logic eEmpty, input logic eFull, input logic eErr);
    @(posedge clock);
    #2;
    oe = val;
    #1;
    pushExp(nm, ePc, eEmpty, eFull, eErr);
  endtask

  task automatic checkOutput(input expT e);
    compared++;
    if (pcValue !== e.pc || countOut !== e.cout || stackEmpty !== e.empty ||
        stackFull !== e.full || stackErr !== e.err) begin
      mismatched++;
      $display("[TB] FAIL %s: got pc=%h out=%b empty=%b full=%b err=%b, expected pc=%h out=%b empty=%b full=%b err=%b",
               e.name, pcValue, countOut, stackEmpty, stackFull, stackErr,
               e.pc, e.cout, e.empty, e.full, e.err);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      while (sb.size() > 0) begin
        checkOutput(sb.pop_front());
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b1;
    {clr, ret, call, jump, inc} = NONE;
    oe = 1'b0;
    countIn = 4'h0;
    #1;
    pushExp("reset", 4'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    #2;
    rstn = 1'b0;

    // Counting through the 4-bit wrap
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(INC, 4'h0, $sformatf("inc%0d", i), 4'(i % 16), 1'b1, 1'b0, 1'b0);
    end

    // Asynchronous reset asserted mid-cycle must clear before the next rising edge
    @(posedge clock);
    #2;
    rstn = 1'b1;
    #1;
    pushExp("async_rst", 4'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    #2;
    rstn = 1'b0;

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(INC, 4'h0, $sformatf("pre_oe%0d", i), 4'(i), 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(NONE, 4'h9, "hold_oe0", 4'h5, 1'b1, 1'b0, 1'b0);
    setOe(1'b1, "oe_on", 4'h5, 1'b1, 1'b0, 1'b0);

    applyStimulus(JMP,       4'h3, "jmp3",     4'h3, 1'b1, 1'b0, 1'b0);
    applyStimulus(JMP,       4'h9, "jmp9",     4'h9, 1'b1, 1'b0, 1'b0);
    applyStimulus(JMP | INC, 4'hF, "jmpinc_f", 4'h0, 1'b1, 1'b0, 1'b0);
    setOe(1'b0, "oe_off", 4'h0, 1'b1, 1'b0, 1'b0);

    // Nested calls and returns
    applyStimulus(JMP,  4'h2, "nest_jmp2", 4'h2, 1'b1, 1'b0, 1'b0);
    applyStimulus(CALL, 4'h8, "call8",     4'h8, 1'b0, 1'b0, 1'b0);
    applyStimulus(CALL, 4'hC, "call12",    4'hC, 1'b0, 1'b1, 1'b0);
    applyStimulus(RET,  4'h0, "ret_a",     4'h9, 1'b0, 1'b0, 1'b0);
    applyStimulus(RET,  4'h0, "ret_b",     4'h3, 1'b1, 1'b0, 1'b0);

    // Overflow, underflow and sticky error
    applyStimulus(JMP,  4'h2, "ov_jmp2",   4'h2, 1'b1, 1'b0, 1'b0);
    applyStimulus(CALL, 4'h8, "ov_call8",  4'h8, 1'b0, 1'b0, 1'b0);
    applyStimulus(CALL, 4'hC, "ov_call12", 4'hC, 1'b0, 1'b1, 1'b0);
    applyStimulus(CALL, 4'h7, "overflow",  4'hC, 1'b0, 1'b1, 1'b1);
    applyStimulus(RET,  4'h0, "ov_ret_a",  4'h9, 1'b0, 1'b0, 1'b1);
    applyStimulus(RET,  4'h0, "ov_ret_b",  4'h3, 1'b1, 1'b0, 1'b1);
    applyStimulus(RET,  4'h0, "underflow", 4'h3, 1'b1, 1'b0, 1'b1);
    applyStimulus(NONE, 4'h0, "err_hold",  4'h3, 1'b1, 1'b0, 1'b1);
    applyStimulus(CLR,  4'h0, "clr",       4'h0, 1'b1, 1'b0, 1'b0);

    // Priority resolution
    applyStimulus(JMP,  4'h5, "pr_jmp5",  4'h5, 1'b1, 1'b0, 1'b0);
    applyStimulus(CALL, 4'hA, "pr_call",  4'hA, 1'b0, 1'b0, 1'b0);
    applyStimulus(CLR | RET | CALL | JMP | INC, 4'h7, "pr_all", 4'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(JMP,  4'h5, "pr_jmp5b", 4'h5, 1'b1, 1'b0, 1'b0);
    applyStimulus(CALL, 4'hA, "pr_callb", 4'hA, 1'b0, 1'b0, 1'b0);
    applyStimulus(RET | CALL, 4'h3, "pr_retcall", 4'h6, 1'b1, 1'b0, 1'b0);
    applyStimulus(CALL | INC, 4'h4, "call_inc",   4'h5, 1'b0, 1'b0, 1'b0);
    applyStimulus(RET,  4'h0, "call_inc_ret", 4'h7, 1'b1, 1'b0, 1'b0);

    repeat (2) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Parametrised successor to the 4-bit SAP-style program counter. Generalises address width and adds a hardware return-address stack for CALL/RET.
- Holds the current instruction address.
- Drives the address onto the shared bus through a tri-state output, and also exposes an always-driven copy for the controller and debug.
- Sits between the control sequencer (clr/jump/call/ret/count_increment/counter_output_enable strobes) and the W-bit system bus.

Parameters:
- WIDTH, 8, address width in bits (≥2); the PC and every stack entry are WIDTH bits.
- DEPTH, 4, return-stack entries (≥1); pointer width is $clog2(DEPTH+1).

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  reset, asynchronous, active-high (asserted = 1 clears the block immediately, independent of clk)
- clr  input  1  synchronous clear of PC, stack and error flag
- jump  input  1  load PC from count_in
- call  input  1  push return address, load PC from count_in
- ret  input  1  pop stack into PC
- count_increment  input  1  PC <= PC+1
- counter_output_enable  input  1  drive count_out onto bus
- count_in  input  WIDTH  target address from bus
- count_out  output  WIDTH  PC when enabled, else all-Z
- pc_value  output  WIDTH  PC, always driven
- stack_empty  output  1  no entries stored
- stack_full  output  1  DEPTH entries stored
- stack_err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (rstn=1, async): pc=0, stack pointer sp=0, stack_err=0. Stack contents don't-care. Outputs during and after reset: pc_value=0, stack_empty=1, stack_full=0, stack_err=0. count_out is Z or 0 according to counter_output_enable. Reset deasserted mid-operation: the first rising edge with rstn=0 evaluates commands normally.
- All state updates occur on posedge clk with rstn=0. Commands are sampled that edge, and the result is visible on pc_value one cycle later.
- Strict priority, one action per cycle: clr > ret > call > jump > count_increment > hold.
  - clr: pc=0, sp=0, stack_err=0, whatever else is asserted.
  - ret, sp>0: pc = stack[sp-1], sp = sp-1.
  - ret, sp=0 (underflow): pc, sp unchanged; stack_err=1.
  - call, sp<DEPTH: stack[sp] = pc+1 (mod 2^WIDTH), sp = sp+1. pc = count_in, or count_in+1 if count_increment is also high.
  - call, sp=DEPTH (overflow): pc, sp, stack unchanged; stack_err=1.
  - jump: pc = count_in; if count_increment is also high, pc = count_in+1 (mod 2^WIDTH). This matches the prior generation's jump+increment behaviour.
  - count_increment alone: pc = pc+1 (mod 2^WIDTH). All-ones wraps to 0 with no flag.
  - none asserted: hold.
- stack_err is sticky. Only reset or clr clears it; further valid calls/rets do not.
- stack_empty = (sp==0) and stack_full = (sp==DEPTH). Both are combinational from the registered sp.
- count_out = counter_output_enable ? pc : {WIDTH{1'bz}}. Combinational, with no cycle latency from the enable.
- Arithmetic is unsigned WIDTH bits; carries are discarded.
- X on any command input is not supported; the bench must keep strobes 0/1.

Test Plan:
1. Reset/wrap (WIDTH=4): assert rstn async mid-cycle → pc_value=0 immediately, stack_empty=1. Release, then count_increment for 17 cycles → pc sequence 1..15, 0, 1.
2. Output enable: pc=5, counter_output_enable=0 → count_out=4'bzzzz. Enable=1 → count_out=4'h5 in the same cycle. pc_value=5 throughout.
3. Jump variants: pc=3; jump, count_in=9 → pc=9. Then jump+count_increment, count_in=4'hF → pc=0.
4. Call/ret nesting (DEPTH=2): pc=2, call 8 → pc=8, sp=1. Call 12 → pc=12, stack_full=1. Ret → pc=9. Ret → pc=3, stack_empty=1.
5. Overflow/underflow: stack full, call 7 → pc, sp unchanged and stack_err=1. Ret ×2 then ret on empty → pc unchanged, stack_err stays 1. clr → pc=0, sp=0, stack_err=0.
6. Priority: clr+ret+call+jump+count_increment in one cycle → pc=0, sp=0. ret+call with sp=1, stack[0]=6 → pc=6, sp=0, no push.
